// File: rtl/isdu_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package isdu_pkg;

    typedef enum logic [2:0] {
        HALTED = 3'b000,
        S18    = 3'b001,
        S33    = 3'b010,
        S35    = 3'b011,
        PAUSE1 = 3'b100,
        PAUSE2 = 3'b101
    } isdu_state_e;

    localparam logic [1:0]  PCMUX_INC = 2'b00;
    localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/isdu_fetch_if.sv
// Control bundle between the fetch sequencer and the datapath/front panel.
interface isdu_fetch_if;

    logic       Run;
    logic       Continue;
    logic       LD_MAR;
    logic       LD_MDR;
    logic       LD_IR;
    logic       LD_PC;
    logic       GatePC;
    logic       GateMDR;
    logic       GateALU;
    logic       GateMARMUX;
    logic [1:0] PCMUX;
    logic       MIO_EN;
    logic       Mem_RD;
    logic [2:0] State;

    modport master (
        input  Run, Continue,
        output LD_MAR, LD_MDR, LD_IR, LD_PC,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, MIO_EN, Mem_RD, State
    );

    modport slave (
        output Run, Continue,
        input  LD_MAR, LD_MDR, LD_IR, LD_PC,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, MIO_EN, Mem_RD, State
    );

endinterface

// File: rtl/isdu_fetch_wait_counter.sv
// Memory read-wait counter: parallel load, saturating decrement, zero flag.
module wait_counter
    import isdu_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/isdu_fetch.sv
// Single-step instruction-fetch sequencer: Run starts, each Continue press
// releases exactly one MAR<-PC / MDR<-M / IR<-MDR fetch.
module isdu_fetch
    import isdu_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    isdu_fetch_if.master bus
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT - 1);

    isdu_state_e state;
    isdu_state_e state_nxt;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= HALTED;
        end else begin
            state <= state_nxt;
        end
    end

    wait_counter #(.W(CNT_W)) u_wait_counter (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt      = state;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = PCMUX_INC;
        bus.MIO_EN     = 1'b0;
        bus.Mem_RD     = 1'b0;
        bus.State      = state;

        unique case (state)
            HALTED: begin
                if (bus.Run) state_nxt = S18;
            end
            S18: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                // Counter is loaded here so it holds MEM_WAIT-1 in the first S33 cycle.
                cnt_load   = 1'b1;
                state_nxt  = S33;
            end
            S33: begin
                bus.MIO_EN = 1'b1;
                bus.Mem_RD = 1'b1;
                if (cnt_zero) begin
                    bus.LD_MDR = 1'b1;
                    state_nxt  = S35;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S35: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
                state_nxt   = PAUSE1;
            end
            PAUSE1: begin
                if (bus.Continue) state_nxt = PAUSE2;
            end
            PAUSE2: begin
                if (!bus.Continue) state_nxt = S18;
            end
            default: state_nxt = HALTED;
        endcase
    end

endmodule

// File: tb/tb_isdu_fetch.sv
// Bench for isdu_fetch: three instances (MEM_WAIT 2, 1, 3) against a
// fetch-schedule reference model.
module tb_isdu_fetch;
    import isdu_pkg::*;

    localparam int NI = 3;

    function automatic int unsigned mw_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic [NI-1:0] rst_n;
    logic          run;
    logic          cont;
    logic [11:0]   obs_vec   [NI];
    logic [2:0]    obs_state [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : inst
        isdu_fetch_if bus ();
        isdu_fetch #(.MEM_WAIT(mw_of(g))) dut (
            .Clk   (clk),
            .Reset (rst_n[g]),
            .bus   (bus)
        );
        assign bus.Run      = run;
        assign bus.Continue = cont;
        assign obs_vec[g]   = {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_PC,
                               bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX,
                               bus.PCMUX, bus.MIO_EN, bus.Mem_RD};
        assign obs_state[g] = bus.State;
    end

    // Model: halted, or el cycles into a fetch (0 = S18), or paused with/without press seen.
    bit m_halt  [NI];
    int m_el    [NI];
    bit m_press [NI];

    int cyc = 0;
    int pc_cnt [NI], mdr_cnt [NI], ir_cnt [NI], s18_cyc [NI], lat [NI], s33_len [NI];

    task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, g, obs, exp);
        end
    endtask

    function automatic void model_reset(input int g);
        m_halt[g]  = 1'b1;
        m_el[g]    = -1;
        m_press[g] = 1'b0;
    endfunction

    function automatic void model_step(input int g, input logic r, input logic c);
        if (!rst_n[g]) begin
            model_reset(g);
        end else if (m_halt[g]) begin
            if (r) begin
                m_halt[g] = 1'b0;
                m_el[g]   = 0;
            end
        end else if (m_el[g] >= 0) begin
            m_el[g]++;
            if (m_el[g] > int'(mw_of(g)) + 1) begin
                m_el[g]    = -1;
                m_press[g] = 1'b0;
            end
        end else if (!m_press[g]) begin
            if (c) m_press[g] = 1'b1;
        end else if (!c) begin
            m_press[g] = 1'b0;
            m_el[g]    = 0;
        end
    endfunction

    task automatic check_all();
        logic [2:0]  es;
        logic [11:0] ev;
        for (int g = 0; g < NI; g++) begin
            int mw = int'(mw_of(g));
            ev = '0;
            if (m_halt[g]) begin
                es = 3'd0;
            end else if (m_el[g] == 0) begin
                es = 3'd1; ev = 12'h980;
            end else if (m_el[g] >= 1 && m_el[g] <= mw) begin
                es = 3'd2; ev = (m_el[g] == mw) ? 12'h403 : 12'h003;
            end else if (m_el[g] == mw + 1) begin
                es = 3'd3; ev = 12'h240;
            end else begin
                es = m_press[g] ? 3'd5 : 3'd4;
            end
            chk("state", g, 32'(obs_state[g]), 32'(es));
            chk("outputs", g, 32'(obs_vec[g]), 32'(ev));
            chk("gate_onehot", g, 32'($countones(obs_vec[g][7:4]) <= 1), 32'd1);
            if (obs_vec[g][8] === 1'b1) begin
                pc_cnt[g]++; s18_cyc[g] = cyc; s33_len[g] = 0;
            end
            if (obs_state[g] === 3'd2) s33_len[g]++;
            if (obs_vec[g][10] === 1'b1) mdr_cnt[g]++;
            if (obs_vec[g][9] === 1'b1) begin
                ir_cnt[g]++; lat[g] = cyc - s18_cyc[g];
            end
        end
    endtask

    task automatic cycle(input logic r, input logic c);
        run  = r;
        cont = c;
        @(posedge clk);
        cyc++;
        for (int g = 0; g < NI; g++) model_step(g, r, c);
        #1;
        check_all();
    endtask

    task automatic async_reset(input int g);
        rst_n[g] = 1'b0;
        model_reset(g);
        #1;
        check_all();
    endtask

    initial begin
        run   = 1'b1;
        cont  = 1'b0;
        rst_n = '0;
        for (int g = 0; g < NI; g++) begin
            model_reset(g);
            pc_cnt[g] = 0; mdr_cnt[g] = 0; ir_cnt[g] = 0;
            s18_cyc[g] = 0; lat[g] = -1; s33_len[g] = 0;
        end
        #1;
        check_all();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);

        rst_n = '1;
        cycle(1'b1, 1'b0);
        for (int g = 0; g < NI; g++) chk("first_edge_s18", g, 32'(obs_state[g]), 32'(S18));

        // Run toggles randomly while fetching; it must be ignored.
        for (int i = 0; i < 6; i++) cycle(1'($urandom_range(0, 1)), 1'b0);
        for (int g = 0; g < NI; g++) begin
            chk("s33_len", g, 32'(s33_len[g]), 32'(mw_of(g)));
            chk("latency", g, 32'(lat[g]), 32'(mw_of(g) + 1));
            chk("mdr_pulses", g, 32'(mdr_cnt[g]), 32'd1);
            chk("in_pause1", g, 32'(obs_state[g]), 32'(PAUSE1));
        end

        for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 1'b0);
        for (int g = 0; g < NI; g++) chk("pause1_hold", g, 32'(obs_state[g]), 32'(PAUSE1));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        for (int g = 0; g < NI; g++) begin
            chk("pause2_hold", g, 32'(obs_state[g]), 32'(PAUSE2));
            pc_cnt[g] = 0;
        end
        cycle(1'b0, 1'b0);
        for (int g = 0; g < NI; g++) chk("release_s18", g, 32'(obs_state[g]), 32'(S18));
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
        for (int g = 0; g < NI; g++) chk("one_pc_per_press", g, 32'(pc_cnt[g]), 32'd1);

        // Abort a MEM_WAIT=3 fetch in its first S33 cycle.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("abort_setup_s33", 2, 32'(obs_state[2]), 32'(S33));
        mdr_cnt[2] = 0;
        ir_cnt[2]  = 0;
        async_reset(2);
        chk("abort_halted", 2, 32'(obs_state[2]), 32'(HALTED));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        rst_n[2] = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        chk("abort_no_mdr", 2, 32'(mdr_cnt[2]), 32'd0);
        chk("abort_no_ir", 2, 32'(ir_cnt[2]), 32'd0);
        chk("abort_stays_halted", 2, 32'(obs_state[2]), 32'(HALTED));

        for (int i = 0; i < 400; i++) begin
            logic nr, nc;
            rst_n = '1;
            if ($urandom_range(0, 49) == 0) async_reset(int'($urandom_range(0, NI - 1)));
            nr = ($urandom_range(0, 7) == 0);
            nc = ($urandom_range(0, 3) == 0) ? ~cont : cont;
            cycle(nr, nc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
